// File: rtl/vga_rx_capture.sv
// rtl/vga_rx_capture.sv - VGA sink: timing lock, 2x decimating capture, frame checksum
//
// Taps a VGA pin stream on clk_vga, locks onto the nominal line/frame timing,
// decimates the 2x-upscaled active picture to CAP_W x CAP_H and emits capture
// buffer writes plus per-frame checksum and timing status.
//
// Ports:
//   clk_vga, reset       pixel clock, synchronous active-high reset
//   vga_hsync/vga_vsync  active-low syncs
//   vga_r/vga_g/vga_b    4-bit colour components
//   cap_we/addr/data     capture write strobe, {y,x} address, {r,g,b} data
//   frame_done/sum       one-cycle pulse and checksum of a completed frame
//   locked, timing_err   lock status and one-cycle violation pulse
//   line_period          last hsync-fall-to-hsync-fall period (saturating)
//   frame_lines          last line count between vsync falls (saturating)
module vga_rx_capture #(
  parameter int H_PERIOD    = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 208,
  parameter int V_PERIOD    = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int CAP_W       = 256,
  parameter int CAP_H       = 240
) (
  input  logic        clk_vga,
  input  logic        reset,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  output logic        cap_we,
  output logic [15:0] cap_addr,
  output logic [11:0] cap_data,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        locked,
  output logic        timing_err,
  output logic [9:0]  line_period,
  output logic [9:0]  frame_lines
);

  localparam logic [9:0]  SAT     = 10'h3FF;
  localparam logic [9:0]  L_HPER  = 10'(H_PERIOD);
  localparam logic [9:0]  L_HSYNC = 10'(H_SYNC);
  localparam logic [9:0]  L_VPER  = 10'(V_PERIOD);
  localparam logic [9:0]  L_VSYNC = 10'(V_SYNC);
  localparam logic [10:0] L_HACT  = 11'(H_ACT_START);
  localparam logic [10:0] L_VACT  = 11'(V_ACT_START);
  localparam logic [10:0] L_CW2   = 11'(2 * CAP_W);
  localparam logic [10:0] L_CH2   = 11'(2 * CAP_H);
  localparam logic [10:0] L_XLAST = 11'(2 * CAP_W - 2);
  localparam logic [10:0] L_YLAST = 11'(2 * CAP_H - 2);

  typedef enum logic [1:0] {S_HUNT, S_LOCKING, S_LOCKED} state_t;

  state_t      state;
  logic        hs_prev;   // previous hsync pin sample
  logic        vs_line;   // vsync sampled on the last hpos=0 cycle
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic [11:0] pix_q;     // colour sample aligned with hpos/vpos
  logic [15:0] acc;
  logic        last_wr;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == SAT) ? v : v + 10'd1;
  endfunction

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [9:0]  hpos_inc, vpos_inc;
  logic        err;
  logic [10:0] x_full, y_full;
  logic        pix_hit;

  always_comb begin
    hs_fall  = hs_prev & ~vga_hsync;
    hs_rise  = ~hs_prev & vga_hsync;
    vs_fall  = hs_fall & vs_line & ~vga_vsync;
    vs_rise  = hs_fall & ~vs_line & vga_vsync;
    hpos_inc = sat_inc(hpos);
    vpos_inc = sat_inc(vpos);
    // hpos_inc/vpos_inc are the values the counters take on this sample,
    // i.e. the ending-line period on a fall and the new position otherwise.
    err = (state != S_HUNT) &&
          ((hs_fall && (hpos_inc != L_HPER)) ||
           (hs_rise && (hpos_inc != L_HSYNC)) ||
           (!hs_fall && (hpos != SAT) && (hpos_inc == SAT)) ||
           (vs_rise && (vpos_inc != L_VSYNC)) ||
           (vs_fall && (vpos_inc != L_VPER)));
    // Capture decision runs one stage after the counters, on registered
    // hpos/vpos/pix_q, giving the two-register pin-to-write latency.
    x_full  = {1'b0, hpos} - L_HACT;
    y_full  = {1'b0, vpos} - L_VACT;
    pix_hit = (state == S_LOCKED) &&
              ({1'b0, hpos} >= L_HACT) && (x_full < L_CW2) && !x_full[0] &&
              ({1'b0, vpos} >= L_VACT) && (y_full < L_CH2) && !y_full[0];
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      state       <= S_HUNT;
      hs_prev     <= 1'b0;
      vs_line     <= 1'b0;
      hpos        <= '0;
      vpos        <= '0;
      pix_q       <= '0;
      acc         <= '0;
      last_wr     <= 1'b0;
      cap_we      <= 1'b0;
      cap_addr    <= '0;
      cap_data    <= '0;
      frame_done  <= 1'b0;
      frame_sum   <= '0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      line_period <= '0;
      frame_lines <= '0;
    end else begin
      hs_prev <= vga_hsync;
      pix_q   <= {vga_r, vga_g, vga_b};

      if (hs_fall) begin
        hpos        <= '0;
        vs_line     <= vga_vsync;
        vpos        <= vs_fall ? 10'd0 : vpos_inc;
        line_period <= hpos_inc;
        if (vs_fall) frame_lines <= vpos_inc;
      end else begin
        hpos <= hpos_inc;
      end

      timing_err <= err;

      unique case (state)
        S_HUNT:    if (vs_fall) state <= S_LOCKING;
        S_LOCKING: if (err) state <= S_HUNT;
                   else if (vs_fall) state <= S_LOCKED;
        S_LOCKED:  if (err) state <= S_HUNT;
        default:   state <= S_HUNT;
      endcase

      // Lags the state by one cycle so it drops the cycle after timing_err.
      locked <= (state == S_LOCKED);

      cap_we <= pix_hit;
      if (pix_hit) begin
        cap_addr <= {y_full[8:1], x_full[8:1]};
        cap_data <= pix_q;
      end

      if (vs_fall)      acc <= '0;
      else if (pix_hit) acc <= acc + {4'h0, pix_q};

      last_wr    <= pix_hit && (x_full == L_XLAST) && (y_full == L_YLAST);
      // Lock is only (re)acquired at a vsync fall, so a last-pixel write in
      // LOCKED implies the whole frame was captured under lock.
      frame_done <= last_wr && (state == S_LOCKED);
      if (last_wr && (state == S_LOCKED)) frame_sum <= acc;
    end
  end

endmodule

// File: tb/tb_vga_rx_capture.sv
// tb/tb_vga_rx_capture.sv - scoreboard bench for vga_rx_capture on a reduced raster
module tb_vga_rx_capture;

  localparam int HP = 80, HS = 8, HA = 12, VP = 30, VS = 2, VA = 3, CW = 32, CH = 12;

  logic        clk_vga = 1'b0;
  logic        reset = 1'b1;
  logic        vga_hsync = 1'b1, vga_vsync = 1'b1;
  logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        cap_we, frame_done, locked, timing_err;
  logic [15:0] cap_addr, frame_sum;
  logic [11:0] cap_data;
  logic [9:0]  line_period, frame_lines;

  always #5 clk_vga = ~clk_vga;

  vga_rx_capture #(
    .H_PERIOD(HP), .H_SYNC(HS), .H_ACT_START(HA), .V_PERIOD(VP),
    .V_SYNC(VS), .V_ACT_START(VA), .CAP_W(CW), .CAP_H(CH)
  ) dut (
    .clk_vga(clk_vga), .reset(reset), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
    .frame_done(frame_done), .frame_sum(frame_sum), .locked(locked),
    .timing_err(timing_err), .line_period(line_period), .frame_lines(frame_lines)
  );

  int errors = 0, checks = 0;
  int cyc = 0, err_cyc = -1, mark_cyc = -2;
  int wr_cnt = 0, n_exp = 0, err_cnt = 0, exp_err = 0, cur_mode = 0;
  int lp_exp = 0;
  bit lp_known = 0, fl_known = 0, mark_pending = 0, err_prev = 0, done_prev = 0;
  logic [27:0] pix_q[$];
  logic [15:0] done_q[$];

  always @(posedge clk_vga) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cap_we"}, cap_we, 0);
    check({tag, "_cap_addr"}, cap_addr, 0);
    check({tag, "_cap_data"}, cap_data, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_sum"}, frame_sum, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_timing_err"}, timing_err, 0);
    check({tag, "_line_period"}, line_period, 0);
    check({tag, "_frame_lines"}, frame_lines, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or frame_done.
  always @(negedge clk_vga) begin
    logic [27:0] e;
    if (cap_we) begin
      wr_cnt++;
      if (pix_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", cap_addr, cap_data);
      end else begin
        e = pix_q.pop_front();
        check("cap_addr", cap_addr, e[27:12]);
        check("cap_data", cap_data, e[11:0]);
      end
      if (cap_addr == 16'h0205 && cur_mode == 0) check("pix_x10_y4", cap_data, 12'h00E);
    end
    if (frame_done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame_done: sum 0x%0h, no frame_done expected", frame_sum);
      end else begin
        check("frame_sum", frame_sum, done_q.pop_front());
      end
      if (done_prev) check("frame_done_width", frame_done, 0);
    end
    if (err_prev) begin
      check("err_width", timing_err, 0);
      check("locked_after_err", locked, 0);
      check("we_after_err", cap_we, 0);
    end
    if (timing_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    err_prev  = timing_err;
    done_prev = frame_done;
  end

  // Drives one frame. sp_line gets period sp_per / hsync width sp_hsw; mark_c
  // flags the sample expected to raise timing_err (mark_c==sp_per means the
  // first sample of the following line); rst_c pulses reset at that sample.
  task automatic send_frame(input int mode, input bit lk, input int cap_upto, input bit exp_done,
                            input int vs_w, input int sp_line, input int sp_per, input int sp_hsw,
                            input int mark_c, input int rst_c);
    logic [15:0] sum;
    logic [11:0] px;
    bit rst_seen;
    int per, hsw, sx, sy;
    sum = '0; rst_seen = 0; cur_mode = mode;
    for (int l = 0; l < VP; l++) begin
      per = (l == sp_line) ? sp_per : HP;
      hsw = (l == sp_line) ? sp_hsw : HS;
      for (int c = 0; c < per; c++) begin
        @(negedge clk_vga);
        if (c == 4) begin
          if (lp_known) check("line_period", line_period, lp_exp);
          if (l == 1) begin
            check("locked", locked, lk);
            if (fl_known) check("frame_lines", frame_lines, VP);
            check("writes_per_frame", wr_cnt, n_exp);
            check("pix_q_drained", pix_q.size(), 0);
            check("done_q_drained", done_q.size(), 0);
            check("err_count", err_cnt, exp_err);
            wr_cnt = 0; n_exp = 0;
          end
        end
        if (mark_pending && c == 0) begin mark_cyc = cyc; mark_pending = 0; end
        if (l == sp_line && c == mark_c) mark_cyc = cyc;
        if (l == sp_line && rst_c >= 0 && c == rst_c + 1) begin
          check_zero("mid_reset");
          reset = 1'b0;
        end
        if (l == sp_line && c == rst_c) begin reset = 1'b1; rst_seen = 1; end
        vga_hsync = (c < hsw) ? 1'b0 : 1'b1;
        vga_vsync = (l < vs_w) ? 1'b0 : 1'b1;
        px = 12'h5A5;
        if (c >= HA && c < HA + 2 * CW && l >= VA && l < VA + 2 * CH) begin
          sx = c - HA; sy = l - VA;
          px = (mode == 0) ? 12'((sx ^ sy) & 12'hFFF) : 12'hFFF;
          if (l < cap_upto && sx % 2 == 0 && sy % 2 == 0) begin
            pix_q.push_back({8'(sy / 2), 8'(sx / 2), px});
            n_exp++;
            sum += {4'h0, px};
            // 384 pixels of 0xFFF: 384*4095 mod 65536 = 0xFE80
            if (exp_done && sx == 2 * CW - 2 && sy == 2 * CH - 2)
              done_q.push_back((mode == 0) ? sum : 16'hFE80);
          end
        end
        {vga_r, vga_g, vga_b} = px;
      end
      if (l == sp_line && mark_c >= per) mark_pending = 1;
      lp_exp   = (per > 1023) ? 1023 : per;
      lp_known = !(l == sp_line && rst_c >= 0);
    end
    fl_known = !rst_seen;
    if (mark_c >= 0) begin
      exp_err++;
      check("err_time", err_cyc, mark_cyc + 1);
    end
  endtask

  initial begin
    repeat (4) @(negedge clk_vga);
    check_zero("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk_vga);
    // Two idle lines with vsync high so the first frame starts on a vsync fall.
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < HP; c++) begin
        @(negedge clk_vga);
        vga_hsync = (c < HS) ? 1'b0 : 1'b1;
        {vga_r, vga_g, vga_b} = 12'h5A5;
      end
    lp_known = 1; lp_exp = HP;
    //         mode lk upto done vsw spl spper  sphsw   mark    rst
    send_frame(0,   0, 0,   0,   VS, -1, HP,    HS,     -1,     -1);  // LOCKING
    send_frame(0,   1, VP,  1,   VS, -1, HP,    HS,     -1,     -1);
    send_frame(0,   1, VP,  1,   VS, -1, HP,    HS,     -1,     -1);
    send_frame(1,   1, VP,  1,   VS, -1, HP,    HS,     -1,     -1);  // constant colour
    send_frame(0,   1, 10,  0,   VS, 10, HP-1,  HS,     HP-1,   -1);  // short line
    send_frame(0,   0, 0,   0,   VS, -1, HP,    HS,     -1,     -1);
    send_frame(0,   1, VP,  1,   VS, -1, HP,    HS,     -1,     -1);
    send_frame(0,   1, 10,  0,   VS, 10, HP,    HS-1,   HS-1,   -1);  // narrow hsync
    send_frame(0,   0, 0,   0,   VS, -1, HP,    HS,     -1,     -1);
    send_frame(0,   1, VP,  1,   VS, -1, HP,    HS,     -1,     -1);
    send_frame(0,   1, 0,   0,   3,  3,  HP,    HS,     0,      -1);  // 3-line vsync
    send_frame(0,   0, 0,   0,   VS, -1, HP,    HS,     -1,     -1);
    send_frame(0,   1, VP,  1,   VS, -1, HP,    HS,     -1,     -1);
    send_frame(0,   1, 10,  0,   VS, 10, 1100,  HS,     1023,   -1);  // missing hsync
    send_frame(0,   0, 0,   0,   VS, -1, HP,    HS,     -1,     -1);
    send_frame(0,   1, VP,  1,   VS, -1, HP,    HS,     -1,     -1);
    send_frame(0,   1, 10,  0,   VS, 10, HP,    HS,     -1,     40);  // mid-frame reset
    send_frame(0,   0, 0,   0,   VS, -1, HP,    HS,     -1,     -1);
    send_frame(0,   1, VP,  1,   VS, -1, HP,    HS,     -1,     -1);
    repeat (20) @(negedge clk_vga);
    check("final_writes", wr_cnt, n_exp);
    check("final_pix_q", pix_q.size(), 0);
    check("final_done_q", done_q.size(), 0);
    check("final_err_count", err_cnt, exp_err);
    check("final_locked", locked, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_rx_capture.md
Name: vga_rx_capture

Overview:
- Sink-side counterpart of the VGA output block. It sits on clk_vga, taps vga_hsync/vga_vsync/vga_r/g/b, and locks onto 800x525 timing.
- It decimates the 2x-upscaled active picture back to 256x240 and writes it into a capture buffer.
- It reports per-frame checksum, lock and timing-error status for on-chip self-test and bench scoreboarding.

Parameters:
H_PERIOD, 800, clocks per line
H_SYNC, 96, hsync low width (clocks)
H_ACT_START, 208, hpos of source column 0
V_PERIOD, 525, lines per frame
V_SYNC, 2, vsync low width (lines)
V_ACT_START, 35, vpos of source line 0
CAP_W, 256, captured columns (source columns 0..2*CAP_W-1, even only)
CAP_H, 240, captured lines (source lines 0..2*CAP_H-1, even only)

Ports:
clk_vga  in  1  pixel clock
reset  in  1  synchronous, active-high
vga_hsync  in  1  horizontal sync, active low
vga_vsync  in  1  vertical sync, active low
vga_r  in  4  red
vga_g  in  4  green
vga_b  in  4  blue
cap_we  out  1  capture buffer write strobe
cap_addr  out  16  {y[7:0], x[7:0]} capture coordinate
cap_data  out  12  {r,g,b}
frame_done  out  1  one-cycle pulse, full frame captured
frame_sum  out  16  checksum of last completed frame
locked  out  1  timing lock status
timing_err  out  1  one-cycle pulse on any timing violation
line_period  out  10  last measured hsync-fall-to-hsync-fall period
frame_lines  out  10  last measured line count between vsync falls

Behaviour:
Reset:
- All outputs are 0.
- FSM enters HUNT; hpos, vpos and the accumulator clear.
- Reset mid-frame aborts capture immediately; no partial frame_done.

Timing reference (pin level):
- hpos=0 on the first cycle vga_hsync is sampled 0 after being 1.
- hpos increments each clock and saturates at 1023.
- vsync is sampled on the hpos=0 cycle.
- vpos=0 on the line where that sample is 0 and the previous line's sample was 1. vpos increments at each hsync fall.

Measurement:
- At each hsync fall, line_period <= hpos+1 of the ending line.
- At each vsync fall, frame_lines <= vpos+1 of the ending frame.
- Both update in every state; values ≥1023 saturate.

FSM:
- HUNT: locked=0, no writes. vsync fall -> LOCKING.
- LOCKING: checks run, no writes. Next vsync fall with frame_lines==V_PERIOD and no error -> LOCKED.
- LOCKED: locked=1, capture enabled. Stays in LOCKED while checks pass.

Checks (active in LOCKING/LOCKED):
- hsync fall with ending line period != H_PERIOD.
- hsync rise at hpos != H_SYNC.
- hpos reaching 1023.
- vsync rise at vpos != V_SYNC.
- vsync fall with frame_lines != V_PERIOD.

Any failed check pulses timing_err for 1 cycle, drops locked the next cycle, and sends the FSM to HUNT. Simultaneous failures produce a single pulse.

Capture (LOCKED only):
- Source coordinates: x = hpos - H_ACT_START, y = vpos - V_ACT_START.
- A pixel is written when x,y are even, 0≤x<2*CAP_W and 0≤y<2*CAP_H.
- Written values: cap_addr={y[8:1],x[8:1]}, cap_data={r,g,b} sampled that cycle.
- cap_we/cap_addr/cap_data appear exactly 2 clocks after the pin sample.
- cap_we is a single-cycle strobe per pixel.

Checksum:
- The accumulator clears at each vsync fall.
- Each written cap_data is added zero-extended, mod 2^16.

Frame done:
- frame_done pulses the cycle after the write of (x=2*CAP_W-2, y=2*CAP_H-2).
- frame_sum latches in that same cycle, including that final pixel.
- frame_done and frame_sum are not produced for a frame in which lock was lost.

Test Plan:
- Ideal 800x525 stream, pixel value = (srcx ^ srcy)&0xFFF:
  - locked rises after the 2nd vsync fall.
  - Exactly 61440 cap_we per frame.
  - Source (x=10,y=4) -> cap_addr=0x0205, cap_data=0x00E.
  - frame_done once per frame; frame_sum equals the bench-computed sum.
- Constant color 0xFFF:
  - frame_sum=(61440*4095) mod 65536=0x1000.
  - line_period=800, frame_lines=525.
- While locked, one line of period 799:
  - timing_err 1-cycle pulse at that hsync fall; locked=0 next cycle; writes stop.
  - Relock two vsync falls later.
- hsync width 95 while locked -> timing_err at hsync rise, FSM to HUNT.
- vsync width 3 lines -> timing_err.
- No hsync for 1100 clocks -> timing_err when hpos hits 1023; line_period=1023 at the next fall.
- Reset asserted mid-active-region while locked:
  - All outputs 0 next cycle; no frame_done for that frame.
  - Relock after 2 vsync falls with correct frame_sum.
